// File: rtl/reg_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : reg_operand_fetch
//  Brief    : Read-side client of the CPU register bank. Accepts an operand
//             request, drives the bank read addresses, captures the
//             registered bank data one cycle later, forwards any in-flight
//             writeback and presents the operands over valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_operand_fetch #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    // request from decode
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs,
    input  logic [ADDR_W-1:0] req_rs2,
    input  logic [ADDR_W-1:0] req_rd,
    input  logic [TAG_W-1:0]  req_tag,
    // register bank read ports
    output logic [ADDR_W-1:0] rf_rs_o,
    output logic [ADDR_W-1:0] rf_rs2_o,
    input  logic [DATA_W-1:0] rf_dat1_i,
    input  logic [DATA_W-1:0] rf_dat2_i,
    // writeback snoop
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_dat,
    // operands to execute
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [ADDR_W-1:0] out_rd,
    output logic [TAG_W-1:0]  out_tag,
    output logic [7:0]        fetch_cnt
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ADDR  = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_VALID = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_rs;
    logic [ADDR_W-1:0] r_rs2;
    logic [ADDR_W-1:0] r_rd;
    logic [TAG_W-1:0]  r_tag;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [DATA_W-1:0] r_fwd1;
    logic [DATA_W-1:0] r_fwd2;
    logic              r_fwd1_v;
    logic              r_fwd2_v;
    logic              r_out_valid;
    logic [7:0]        r_fetch_cnt;

    logic              w_req_ready;
    logic              w_req_fire;
    logic              w_out_fire;
    logic              w_wb_hit1;
    logic              w_wb_hit2;
    logic [DATA_W-1:0] w_cap_a;
    logic [DATA_W-1:0] w_cap_b;

    // Handshake and writeback-match decode. A writeback on the current edge
    // beats a value saved during ADDR, which beats the bank read data.
    always_comb begin
        w_req_ready = (r_state == c_IDLE) || ((r_state == c_VALID) && out_ready);
        w_req_fire  = req_valid && w_req_ready;
        w_out_fire  = r_out_valid && out_ready;
        w_wb_hit1   = wb_en && (wb_rd == r_rs);
        w_wb_hit2   = wb_en && (wb_rd == r_rs2);
        w_cap_a     = w_wb_hit1 ? wb_dat : (r_fwd1_v ? r_fwd1 : rf_dat1_i);
        w_cap_b     = w_wb_hit2 ? wb_dat : (r_fwd2_v ? r_fwd2 : rf_dat2_i);
    end

    // Sequencer: IDLE -> ADDR -> DATA -> VALID, with VALID able to accept
    // the next request directly so back-to-back requests skip IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE:  if (w_req_fire) r_state <= c_ADDR;
                c_ADDR:  r_state <= c_DATA;
                c_DATA:  r_state <= c_VALID;
                c_VALID: begin
                    if (w_out_fire) begin
                        r_state <= req_valid ? c_ADDR : c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Request latch: addresses drive the bank directly, rd/tag ride along.
    // Held in IDLE and VALID so the bank keeps reading the same registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rs  <= '0;
            r_rs2 <= '0;
            r_rd  <= '0;
            r_tag <= '0;
        end else if (w_req_fire) begin
            r_rs  <= req_rs;
            r_rs2 <= req_rs2;
            r_rd  <= req_rd;
            r_tag <= req_tag;
        end
    end

    // Forward capture: a write committed at the edge ending ADDR lands in
    // the bank too late to appear in its registered output, so keep a copy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fwd1   <= '0;
            r_fwd2   <= '0;
            r_fwd1_v <= 1'b0;
            r_fwd2_v <= 1'b0;
        end else if (r_state == c_ADDR) begin
            r_fwd1_v <= w_wb_hit1;
            r_fwd2_v <= w_wb_hit2;
            if (w_wb_hit1) r_fwd1 <= wb_dat;
            if (w_wb_hit2) r_fwd2 <= wb_dat;
        end else if (r_state == c_DATA) begin
            r_fwd1_v <= 1'b0;
            r_fwd2_v <= 1'b0;
        end
    end

    // Operand registers: captured in DATA, then kept architecturally current
    // while presented by snooping writebacks to the held source indices.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_op_a <= '0;
            r_op_b <= '0;
        end else if (r_state == c_DATA) begin
            r_op_a <= w_cap_a;
            r_op_b <= w_cap_b;
        end else if (r_state == c_VALID) begin
            if (w_wb_hit1) r_op_a <= wb_dat;
            if (w_wb_hit2) r_op_b <= wb_dat;
        end
    end

    // Output valid flag and completed-handshake counter (wraps modulo 256).
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_fetch_cnt <= 8'd0;
        end else begin
            if (r_state == c_DATA) begin
                r_out_valid <= 1'b1;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
            if (w_out_fire) begin
                r_fetch_cnt <= r_fetch_cnt + 8'd1;
            end
        end
    end

    assign req_ready = w_req_ready;
    assign rf_rs_o   = r_rs;
    assign rf_rs2_o  = r_rs2;
    assign out_valid = r_out_valid;
    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign out_rd    = r_rd;
    assign out_tag   = r_tag;
    assign fetch_cnt = r_fetch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_reg_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_operand_fetch
//  Brief    : Self-checking bench for reg_operand_fetch. Owns a register bank
//             with one-cycle registered reads and an abstract model that
//             tracks the outstanding request, its age and the handshake count.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_operand_fetch;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int TAG_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_rs, req_rs2, req_rd;
    logic [TAG_W-1:0]  req_tag;
    logic [ADDR_W-1:0] rf_rs_o, rf_rs2_o;
    logic [DATA_W-1:0] rf_dat1, rf_dat2;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_dat;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] op_a, op_b;
    logic [ADDR_W-1:0] out_rd;
    logic [TAG_W-1:0]  out_tag;
    logic [7:0]        fetch_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // register bank: architectural state, registered read ports
    logic [DATA_W-1:0] rf [8];

    // model of the block: outstanding request and cycles since acceptance
    bit                m_busy = 1'b0;
    int                m_age  = 0;
    logic [ADDR_W-1:0] m_rs = '0, m_rs2 = '0, m_rd = '0;
    logic [TAG_W-1:0]  m_tag = '0;
    logic [7:0]        m_cnt = 8'd0;

    reg_operand_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs(req_rs), .req_rs2(req_rs2), .req_rd(req_rd), .req_tag(req_tag),
        .rf_rs_o(rf_rs_o), .rf_rs2_o(rf_rs2_o),
        .rf_dat1_i(rf_dat1), .rf_dat2_i(rf_dat2),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_dat(wb_dat),
        .out_valid(out_valid), .out_ready(out_ready),
        .op_a(op_a), .op_b(op_b), .out_rd(out_rd), .out_tag(out_tag),
        .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    // bank: read returns the value before a same-edge write
    always @(posedge clk) begin
        rf_dat1 <= rf[rf_rs_o];
        rf_dat2 <= rf[rf_rs2_o];
        if (wb_en) rf[wb_rd] <= wb_dat;
    end

    // operands become visible two edges after acceptance
    function automatic bit m_presenting();
        return m_busy && (m_age >= 2);
    endfunction

    function automatic bit m_ready();
        return !m_busy || (m_presenting() && out_ready);
    endfunction

    // advance one clock and update the model from the inputs seen at the edge
    task automatic tick();
        bit acc, hs, r;
        logic [ADDR_W-1:0] a, b, d;
        logic [TAG_W-1:0]  t;
        r   = rst;
        acc = r && req_valid && m_ready();
        hs  = r && m_presenting() && out_ready;
        a = req_rs; b = req_rs2; d = req_rd; t = req_tag;
        @(posedge clk);
        #1;
        if (!r) begin
            m_busy = 1'b0; m_age = 0; m_cnt = 8'd0;
        end else begin
            if (hs) begin
                m_cnt  = m_cnt + 8'd1;
                m_busy = 1'b0;
            end else if (m_busy && m_age < 2) begin
                m_age++;
            end
            if (acc) begin
                m_busy = 1'b1; m_age = 0;
                m_rs = a; m_rs2 = b; m_rd = d; m_tag = t;
            end
        end
    endtask

    task automatic write_reg(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        wb_en = 1'b1; wb_rd = r; wb_dat = d;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic send(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                        input logic [ADDR_W-1:0] d, input logic [TAG_W-1:0] t);
        req_valid = 1'b1; req_rs = a; req_rs2 = b; req_rd = d; req_tag = t;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b0; out_ready = 1'b0; wb_en = 1'b0;
        req_rs = '0; req_rs2 = '0; req_rd = '0; req_tag = '0; wb_rd = '0; wb_dat = '0;
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %0h want 0", out_valid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset req_ready: got %0h want 1", req_ready); end
        n_cmp++; if (op_a !== 8'h00) begin n_bad++; $display("FAIL reset op_a: got %0h want 0", op_a); end
        n_cmp++; if (op_b !== 8'h00) begin n_bad++; $display("FAIL reset op_b: got %0h want 0", op_b); end
        n_cmp++; if (out_rd !== 3'd0) begin n_bad++; $display("FAIL reset out_rd: got %0h want 0", out_rd); end
        n_cmp++; if (out_tag !== 4'd0) begin n_bad++; $display("FAIL reset out_tag: got %0h want 0", out_tag); end
        n_cmp++; if (rf_rs_o !== 3'd0 || rf_rs2_o !== 3'd0) begin n_bad++; $display("FAIL reset rf addr: got %0h/%0h want 0/0", rf_rs_o, rf_rs2_o); end
        n_cmp++; if (fetch_cnt !== 8'd0) begin n_bad++; $display("FAIL reset fetch_cnt: got %0d want 0", fetch_cnt); end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 8; i++) write_reg(3'(i), 8'($urandom));
        write_reg(3'd2, 8'h3C);
        write_reg(3'd5, 8'hA1);
        send(3'd2, 3'd5, 3'd7, 4'h9);
        n_cmp++; if (rf_rs_o !== 3'd2 || rf_rs2_o !== 3'd5) begin n_bad++; $display("FAIL basic rf addr: got %0h/%0h want 2/5", rf_rs_o, rf_rs2_o); end
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL basic busy ready: got %0h want 0", req_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic early valid: got %0h want 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic latency valid: got %0h want 1", out_valid); end
        n_cmp++; if (op_a !== 8'h3C || op_b !== 8'hA1) begin n_bad++; $display("FAIL basic ops: got %0h/%0h want 3c/a1", op_a, op_b); end
        n_cmp++; if (out_rd !== 3'd7 || out_tag !== 4'h9) begin n_bad++; $display("FAIL basic rd/tag: got %0h/%0h want 7/9", out_rd, out_tag); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (fetch_cnt !== 8'd1) begin n_bad++; $display("FAIL basic fetch_cnt: got %0d want 1", fetch_cnt); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic valid drop: got %0h want 0", out_valid); end
    endtask

    task automatic test_addr_fwd();
        write_reg(3'd3, 8'h11);
        write_reg(3'd0, 8'h00);
        send(3'd3, 3'd0, 3'd1, 4'h2);
        write_reg(3'd3, 8'h55);
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL addrfwd valid: got %0h want 1", out_valid); end
        n_cmp++; if (op_a !== 8'h55 || op_b !== 8'h00) begin n_bad++; $display("FAIL addrfwd ops: got %0h/%0h want 55/00", op_a, op_b); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_data_fwd();
        send(3'd4, 3'd4, 3'd2, 4'h3);
        write_reg(3'd4, 8'h20);
        write_reg(3'd4, 8'h21);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL datafwd valid: got %0h want 1", out_valid); end
        n_cmp++; if (op_a !== 8'h21 || op_b !== 8'h21) begin n_bad++; $display("FAIL datafwd ops: got %0h/%0h want 21/21", op_a, op_b); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_stall();
        write_reg(3'd1, 8'h10);
        write_reg(3'd6, 8'h66);
        send(3'd1, 3'd6, 3'd5, 4'hC);
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            wb_en = (i == 1); wb_rd = 3'd1; wb_dat = 8'hEE;
            tick();
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stall valid %0d: got %0h want 1", i, out_valid); end
            n_cmp++; if (op_a !== ((i >= 1) ? 8'hEE : 8'h10)) begin n_bad++; $display("FAIL stall op_a %0d: got %0h want %0h", i, op_a, (i >= 1) ? 8'hEE : 8'h10); end
            n_cmp++; if (op_b !== 8'h66 || out_tag !== 4'hC || out_rd !== 3'd5) begin n_bad++; $display("FAIL stall hold %0d: got %0h/%0h/%0h want 66/c/5", i, op_b, out_tag, out_rd); end
        end
        wb_en = 1'b0;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        n_cmp++; if (fetch_cnt !== 8'd4) begin n_bad++; $display("FAIL stall fetch_cnt: got %0d want 4", fetch_cnt); end
    endtask

    task automatic test_reset_mid();
        send(3'd2, 3'd5, 3'd0, 4'h1);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid valid: got %0h want 0", out_valid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid ready: got %0h want 1", req_ready); end
        n_cmp++; if (fetch_cnt !== 8'd0) begin n_bad++; $display("FAIL rstmid fetch_cnt: got %0d want 0", fetch_cnt); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid ghost valid %0d: got %0h want 0", i, out_valid); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; out_ready = 1'b1;
        for (int t = 1; t <= 769; t++) begin
            req_rs = 3'($urandom); req_rs2 = 3'($urandom); req_rd = 3'($urandom); req_tag = 4'($urandom);
            wb_en = ($urandom_range(0, 2) == 0); wb_rd = 3'($urandom); wb_dat = 8'($urandom);
            tick();
            n_cmp++; if (req_ready !== m_ready()) begin n_bad++; $display("FAIL b2b ready t=%0d: got %0h want %0h", t, req_ready, m_ready()); end
            n_cmp++; if (out_valid !== m_presenting()) begin n_bad++; $display("FAIL b2b valid t=%0d: got %0h want %0h", t, out_valid, m_presenting()); end
            n_cmp++; if (fetch_cnt !== m_cnt) begin n_bad++; $display("FAIL b2b fetch_cnt t=%0d: got %0d want %0d", t, fetch_cnt, m_cnt); end
            if (m_busy) begin
                n_cmp++; if (rf_rs_o !== m_rs || rf_rs2_o !== m_rs2) begin n_bad++; $display("FAIL b2b addr t=%0d: got %0h/%0h want %0h/%0h", t, rf_rs_o, rf_rs2_o, m_rs, m_rs2); end
            end
            if (m_presenting()) begin
                n_cmp++; if (op_a !== rf[m_rs] || op_b !== rf[m_rs2]) begin n_bad++; $display("FAIL b2b ops t=%0d: got %0h/%0h want %0h/%0h", t, op_a, op_b, rf[m_rs], rf[m_rs2]); end
                n_cmp++; if (out_rd !== m_rd || out_tag !== m_tag) begin n_bad++; $display("FAIL b2b rd/tag t=%0d: got %0h/%0h want %0h/%0h", t, out_rd, out_tag, m_rd, m_tag); end
            end
            if (t == 768) begin
                n_cmp++; if (fetch_cnt !== 8'd255) begin n_bad++; $display("FAIL b2b pre-wrap: got %0d want 255", fetch_cnt); end
            end
            if (t == 769) begin
                n_cmp++; if (fetch_cnt !== 8'd0) begin n_bad++; $display("FAIL b2b wrap: got %0d want 0", fetch_cnt); end
            end
        end
        req_valid = 1'b0; out_ready = 1'b0; wb_en = 1'b0;
    endtask

    task automatic test_random();
        for (int t = 0; t < 600; t++) begin
            req_valid = ($urandom_range(0, 1) == 1); out_ready = ($urandom_range(0, 2) != 0);
            req_rs = 3'($urandom); req_rs2 = ($urandom_range(0, 3) == 0) ? req_rs : 3'($urandom);
            req_rd = 3'($urandom); req_tag = 4'($urandom);
            wb_en = ($urandom_range(0, 1) == 1); wb_rd = 3'($urandom); wb_dat = 8'($urandom);
            tick();
            n_cmp++; if (req_ready !== m_ready()) begin n_bad++; $display("FAIL rnd ready t=%0d: got %0h want %0h", t, req_ready, m_ready()); end
            n_cmp++; if (out_valid !== m_presenting()) begin n_bad++; $display("FAIL rnd valid t=%0d: got %0h want %0h", t, out_valid, m_presenting()); end
            n_cmp++; if (fetch_cnt !== m_cnt) begin n_bad++; $display("FAIL rnd fetch_cnt t=%0d: got %0d want %0d", t, fetch_cnt, m_cnt); end
            if (m_presenting()) begin
                n_cmp++; if (op_a !== rf[m_rs] || op_b !== rf[m_rs2]) begin n_bad++; $display("FAIL rnd ops t=%0d: got %0h/%0h want %0h/%0h", t, op_a, op_b, rf[m_rs], rf[m_rs2]); end
                n_cmp++; if (out_rd !== m_rd || out_tag !== m_tag) begin n_bad++; $display("FAIL rnd rd/tag t=%0d: got %0h/%0h want %0h/%0h", t, out_rd, out_tag, m_rd, m_tag); end
            end
        end
        req_valid = 1'b0; out_ready = 1'b0; wb_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_addr_fwd();
        test_data_fwd();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
